// File: rtl/instr_fetch_unit.sv
// Instruction fetch: word-index PC, synchronous-ROM reads, FWFT prefetch FIFO, redirect flush.
// Optional macro FETCH_STATS_EN adds saturating fetch_count / flush_count outputs.
module instr_fetch_unit #(
   parameter int ROM_DEPTH  = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int PC_W       = 32
) (
   input  logic            clk,
   input  logic            reset,
   output logic            rom_req,
   output logic [PC_W-1:0] rom_addr,
   input  logic [31:0]     rom_data,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]     fetch_count,
   output logic [15:0]     flush_count
`endif
);

   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int CW = FW + 1;
   localparam logic [PC_W-1:0] PC_MASK  = PC_W'(ROM_DEPTH - 1);
   localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   FIFO_CAP = CW'(FIFO_DEPTH);
   localparam logic [FW-1:0]   PTR_ONE  = FW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic            pend_q, pend_d;
   logic [PC_W-1:0] pend_pc_q, pend_pc_d;
   logic [FW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     mem_instr_q [FIFO_DEPTH];
   logic [31:0]     mem_instr_d [FIFO_DEPTH];
   logic [PC_W-1:0] mem_pc_q [FIFO_DEPTH];
   logic [PC_W-1:0] mem_pc_d [FIFO_DEPTH];

   logic            redir_s, push_s, pop_s, rom_req_s;
   logic [CW-1:0]   credit_s;

   // Credit counts buffered words plus the in-flight read, so a full FIFO never sees a push
   always_comb begin
      redir_s   = redirect_valid && (state_q != ST_IDLE);
      credit_s  = count_q + {{FW{1'b0}}, pend_q};
      rom_req_s = (state_q == ST_RUN) && !redirect_valid && (credit_s < FIFO_CAP);
      push_s    = pend_q && !redir_s;
      pop_s     = (count_q != {CW{1'b0}}) && instr_ready && !redir_s;
   end

   assign rom_req     = rom_req_s;
   assign rom_addr    = fetch_pc_q;
   assign instr_valid = (count_q != {CW{1'b0}});
   assign instr       = mem_instr_q[rd_ptr_q];
   assign instr_pc    = mem_pc_q[rd_ptr_q];

   // Next-state: FSM, PC advance, pending read tracking, FIFO push/pop and flush
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      pend_d      = 1'b0;
      pend_pc_d   = pend_pc_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mem_instr_d = mem_instr_q;
      mem_pc_d    = mem_pc_q;

      case (state_q)
         ST_IDLE:  state_d = ST_RUN;
         ST_RUN:   if (halt) state_d = ST_DRAIN; else state_d = ST_RUN;
         ST_DRAIN: if (!halt) state_d = ST_RUN; else state_d = ST_DRAIN;
         default:  state_d = ST_IDLE;
      endcase

      if (redir_s) begin
         // Dropping pend discards the returning stale word
         fetch_pc_d = redirect_pc & PC_MASK;
         pend_d     = 1'b0;
         count_d    = {CW{1'b0}};
         rd_ptr_d   = wr_ptr_q;
      end else begin
         if (rom_req_s) begin
            fetch_pc_d = (fetch_pc_q + PC_ONE) & PC_MASK;
            pend_d     = 1'b1;
            pend_pc_d  = fetch_pc_q;
         end else begin
            pend_d     = 1'b0;
         end
         if (push_s) begin
            mem_instr_d[wr_ptr_q] = rom_data;
            mem_pc_d[wr_ptr_q]    = pend_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d              = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= {PC_W{1'b0}};
         pend_q     <= 1'b0;
         pend_pc_q  <= {PC_W{1'b0}};
         wr_ptr_q   <= {FW{1'b0}};
         rd_ptr_q   <= {FW{1'b0}};
         count_q    <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_instr_q[i] <= 32'd0;
            mem_pc_q[i]    <= {PC_W{1'b0}};
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         pend_q      <= pend_d;
         pend_pc_q   <= pend_pc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_instr_q <= mem_instr_d;
         mem_pc_q    <= mem_pc_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [15:0] fetch_count_q, fetch_count_d;
   logic [15:0] flush_count_q, flush_count_d;

   // Saturating counters; a flush counts only when something was actually discarded
   always_comb begin
      fetch_count_d = fetch_count_q;
      flush_count_d = flush_count_q;
      if (pop_s && (fetch_count_q != 16'hFFFF)) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end else begin
         fetch_count_d = fetch_count_q;
      end
      if (redir_s && ((count_q != {CW{1'b0}}) || pend_q) && (flush_count_q != 16'hFFFF)) begin
         flush_count_d = flush_count_q + 16'd1;
      end else begin
         flush_count_d = flush_count_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count_q <= 16'd0;
         flush_count_q <= 16'd0;
      end else begin
         fetch_count_q <= fetch_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a token-counting reference model of the fetch stream.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   localparam int ROM_DEPTH  = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int PC_W       = 32;
   localparam int AW         = $clog2(ROM_DEPTH);

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rom_req;
   logic [PC_W-1:0] rom_addr;
   logic [31:0]     rom_data = 32'd0;
   logic            instr_valid;
   logic [31:0]     instr;
   logic [PC_W-1:0] instr_pc;
   logic            instr_ready = 1'b0;
   logic            redirect_valid = 1'b0;
   logic [PC_W-1:0] redirect_pc = '0;
   logic            halt = 1'b0;
`ifdef FETCH_STATS_EN
   logic [15:0]     fetch_count;
   logic [15:0]     flush_count;
`endif

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] rom_mem [ROM_DEPTH];

   instr_fetch_unit #(.ROM_DEPTH(ROM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .PC_W(PC_W)) dut (
`ifdef FETCH_STATS_EN
      .fetch_count(fetch_count),
      .flush_count(flush_count),
`endif
      .clk(clk), .reset(reset), .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data returns the cycle after the strobe
   always @(posedge clk) if (rom_req) rom_data <= rom_mem[rom_addr[AW-1:0]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rom_linear();
      for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 32'(100 + i);
   endtask

   task automatic do_reset();
      reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      @(negedge clk);
      n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", instr_valid); else n_pass++;
      n_total++; if (rom_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", rom_req); else n_pass++;
      n_total++; if (rom_addr !== 32'd0) $display("FAIL reset_addr: got %0d want 0", rom_addr); else n_pass++;
      n_total++; if (instr !== 32'd0) $display("FAIL reset_instr: got %0d want 0", instr); else n_pass++;
      n_total++; if (instr_pc !== 32'd0) $display("FAIL reset_pc: got %0d want 0", instr_pc); else n_pass++;
   endtask

   task automatic test_startup();
      fill_rom_linear();
      do_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      n_total++; if (rom_req !== 1'b0) $display("FAIL start_idle_req: got %0b want 0", rom_req); else n_pass++;
      tick(); @(negedge clk);
      n_total++; if (rom_req !== 1'b1) $display("FAIL start_req0: got %0b want 1", rom_req); else n_pass++;
      n_total++; if (rom_addr !== 32'd0) $display("FAIL start_addr0: got %0d want 0", rom_addr); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL start_valid_c1: got %0b want 0", instr_valid); else n_pass++;
      tick(); @(negedge clk);
      n_total++; if (rom_addr !== 32'd1) $display("FAIL start_addr1: got %0d want 1", rom_addr); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL start_valid_c2: got %0b want 0", instr_valid); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         tick(); @(negedge clk);
         n_total++; if (instr_valid !== 1'b1) $display("FAIL start_valid k=%0d: got %0b want 1", k, instr_valid); else n_pass++;
         n_total++; if (instr !== 32'(100 + k)) $display("FAIL start_instr k=%0d: got %0d want %0d", k, instr, 100 + k); else n_pass++;
         n_total++; if (instr_pc !== 32'(k)) $display("FAIL start_pc k=%0d: got %0d want %0d", k, instr_pc, k); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int nreq;
      int got;
      int addrs[$];
      nreq = 0; got = 0;
      fill_rom_linear();
      do_reset();
      repeat (12) begin
         @(negedge clk);
         if (rom_req) begin nreq++; addrs.push_back(int'(rom_addr)); end
         tick();
      end
      n_total++; if (nreq !== FIFO_DEPTH) $display("FAIL bp_req_count: got %0d want %0d", nreq, FIFO_DEPTH); else n_pass++;
      for (int i = 0; i < addrs.size() && i < FIFO_DEPTH; i++) begin
         n_total++; if (addrs[i] !== i) $display("FAIL bp_addr %0d: got %0d want %0d", i, addrs[i], i); else n_pass++;
      end
      @(negedge clk);
      n_total++; if (rom_req !== 1'b0) $display("FAIL bp_req_full: got %0b want 0", rom_req); else n_pass++;
      tick();
      instr_ready = 1'b1;
      for (int c = 0; c < 30 && got < 6; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            n_total++; if (instr_pc !== 32'(got)) $display("FAIL bp_pc %0d: got %0d want %0d", got, instr_pc, got); else n_pass++;
            n_total++; if (instr !== 32'(100 + got)) $display("FAIL bp_instr %0d: got %0d want %0d", got, instr, 100 + got); else n_pass++;
            got++;
         end
         tick();
      end
      n_total++; if (got !== 6) $display("FAIL bp_delivered: got %0d want 6", got); else n_pass++;
   endtask

   task automatic test_wrap();
      int pcs[$];
      int ins[$];
      int areq[$];
      fill_rom_linear();
      do_reset();
      instr_ready = 1'b1;
      for (int c = 0; c < 40 && pcs.size() < 18; c++) begin
         @(negedge clk);
         if (rom_req) areq.push_back(int'(rom_addr));
         if (instr_valid) begin pcs.push_back(int'(instr_pc)); ins.push_back(int'(instr)); end
         tick();
      end
      n_total++; if (pcs.size() !== 18) $display("FAIL wrap_count: got %0d want 18", pcs.size()); else n_pass++;
      for (int i = 12; i < pcs.size(); i++) begin
         n_total++; if (pcs[i] !== i % ROM_DEPTH) $display("FAIL wrap_pc %0d: got %0d want %0d", i, pcs[i], i % ROM_DEPTH); else n_pass++;
         n_total++; if (ins[i] !== 100 + i % ROM_DEPTH) $display("FAIL wrap_instr %0d: got %0d want %0d", i, ins[i], 100 + i % ROM_DEPTH); else n_pass++;
      end
      n_total++;
      if (areq.size() < 17) $display("FAIL wrap_addr: got %0d requests want >=17", areq.size());
      else if (areq[16] !== 0) $display("FAIL wrap_addr: got %0d want 0", areq[16]);
      else n_pass++;
   endtask

   task automatic test_redirect();
      int got;
      got = 0;
      fill_rom_linear();
      do_reset();
      repeat (5) tick();
      redirect_valid = 1'b1; redirect_pc = 32'd9;
      @(negedge clk);
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) $display("FAIL redir_pre: got valid=%0b pc=%0d want 1/0", instr_valid, instr_pc); else n_pass++;
      n_total++; if (rom_req !== 1'b0) $display("FAIL redir_req_same: got %0b want 0", rom_req); else n_pass++;
      tick();
      redirect_valid = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_valid_after: got %0b want 0", instr_valid); else n_pass++;
      n_total++; if (rom_req !== 1'b1 || rom_addr !== 32'd9) $display("FAIL redir_next_req: got req=%0b addr=%0d want 1/9", rom_req, rom_addr); else n_pass++;
`ifdef FETCH_STATS_EN
      n_total++; if (flush_count !== 16'd1) $display("FAIL redir_flush_count: got %0d want 1", flush_count); else n_pass++;
`endif
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            n_total++; if (instr_pc !== 32'(9 + got) || instr !== 32'(109 + got)) $display("FAIL redir_stream %0d: got pc=%0d instr=%0d want %0d/%0d", got, instr_pc, instr, 9 + got, 109 + got); else n_pass++;
            got++;
         end
         tick();
      end
      n_total++; if (got !== 3) $display("FAIL redir_delivered: got %0d want 3", got); else n_pass++;
      redirect_valid = 1'b1; redirect_pc = 32'd5; tick();
      redirect_pc = 32'd2; tick();
      redirect_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && got < 1; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            n_total++; if (instr_pc !== 32'd2 || instr !== 32'd102) $display("FAIL b2b_redir: got pc=%0d instr=%0d want 2/102", instr_pc, instr); else n_pass++;
            got++;
         end
         tick();
      end
      n_total++; if (got !== 1) $display("FAIL b2b_delivered: got %0d want 1", got); else n_pass++;
   endtask

   task automatic test_halt();
      int got;
      got = 0;
      fill_rom_linear();
      do_reset();
      instr_ready = 1'b1;
      tick();
      halt = 1'b1;
      tick();
      @(negedge clk);
      n_total++; if (rom_req !== 1'b0) $display("FAIL halt_req_c2: got %0b want 0", rom_req); else n_pass++;
      tick(); @(negedge clk);
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'd100) $display("FAIL halt_pending_word: got valid=%0b pc=%0d instr=%0d want 1/0/100", instr_valid, instr_pc, instr); else n_pass++;
      for (int c = 0; c < 5; c++) begin
         tick(); @(negedge clk);
         n_total++; if (rom_req !== 1'b0) $display("FAIL halt_req_hold %0d: got %0b want 0", c, rom_req); else n_pass++;
      end
      tick();
      halt = 1'b0;
      tick(); @(negedge clk);
      n_total++; if (rom_req !== 1'b1 || rom_addr !== 32'd1) $display("FAIL halt_resume: got req=%0b addr=%0d want 1/1", rom_req, rom_addr); else n_pass++;
      for (int c = 0; c < 10 && got < 1; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            n_total++; if (instr_pc !== 32'd1 || instr !== 32'd101) $display("FAIL halt_next_word: got pc=%0d instr=%0d want 1/101", instr_pc, instr); else n_pass++;
            got++;
         end
         tick();
      end
      n_total++; if (got !== 1) $display("FAIL halt_delivered: got %0d want 1", got); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int got;
      got = 0;
      fill_rom_linear();
      do_reset();
      repeat (6) tick();
      @(negedge clk);
      n_total++; if (instr_valid !== 1'b1 || rom_req !== 1'b0) $display("FAIL rstmid_full: got valid=%0b req=%0b want 1/0", instr_valid, rom_req); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_total++; if (instr_valid !== 1'b0 || rom_req !== 1'b0 || rom_addr !== 32'd0) $display("FAIL rstmid_async: got valid=%0b req=%0b addr=%0d want 0/0/0", instr_valid, rom_req, rom_addr); else n_pass++;
      instr_ready = 1'b1;
      @(posedge clk); #1 reset = 1'b1;
      tick(); @(negedge clk);
      n_total++; if (rom_req !== 1'b1 || rom_addr !== 32'd0) $display("FAIL rstmid_restart: got req=%0b addr=%0d want 1/0", rom_req, rom_addr); else n_pass++;
      for (int c = 0; c < 10 && got < 1; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            n_total++; if (instr_pc !== 32'd0 || instr !== 32'd100) $display("FAIL rstmid_first: got pc=%0d instr=%0d want 0/100", instr_pc, instr); else n_pass++;
            got++;
         end
         tick();
      end
      n_total++; if (got !== 1) $display("FAIL rstmid_delivered: got %0d want 1", got); else n_pass++;
   endtask

   // Model: fetch stream is consecutive PCs from the last target; tokens = reads not yet consumed
   task automatic test_random();
      int  started, halt_prev, outstanding, inflight, req_pc, exp_pc, pops, flushes;
      bit  exp_req, exp_valid;
      started = 0; halt_prev = 0; outstanding = 0; inflight = 0; req_pc = 0; exp_pc = 0; pops = 0; flushes = 0;
      for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = $urandom;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         if ($urandom_range(0, 19) == 0) halt = ~halt;
         @(negedge clk);
         exp_req   = (started != 0) && (halt_prev == 0) && !redirect_valid && (outstanding < FIFO_DEPTH);
         exp_valid = (outstanding - inflight) > 0;
         n_total++; if (rom_req !== exp_req) $display("FAIL rnd_req cyc %0d: got %0b want %0b", c, rom_req, exp_req); else n_pass++;
         if (exp_req) begin
            n_total++; if (rom_addr !== 32'(req_pc)) $display("FAIL rnd_addr cyc %0d: got %0d want %0d", c, rom_addr, req_pc); else n_pass++;
         end
         n_total++; if (instr_valid !== exp_valid) $display("FAIL rnd_valid cyc %0d: got %0b want %0b", c, instr_valid, exp_valid); else n_pass++;
         if (exp_valid) begin
            n_total++; if (instr_pc !== 32'(exp_pc) || instr !== rom_mem[exp_pc]) $display("FAIL rnd_head cyc %0d: got pc=%0d instr=%0h want %0d/%0h", c, instr_pc, instr, exp_pc, rom_mem[exp_pc]); else n_pass++;
         end
         if (redirect_valid && started != 0) begin
            if (outstanding > 0) flushes++;
            outstanding = 0; inflight = 0;
            req_pc = int'(redirect_pc[AW-1:0]); exp_pc = req_pc;
         end else begin
            if (exp_valid && instr_ready) begin
               outstanding--; pops++; exp_pc = (exp_pc + 1) % ROM_DEPTH;
            end
            if (exp_req) begin
               outstanding++; inflight = 1; req_pc = (req_pc + 1) % ROM_DEPTH;
            end else begin
               inflight = 0;
            end
         end
         halt_prev = (started != 0) ? int'(halt) : 0;
         started = 1;
         tick();
      end
      redirect_valid = 1'b0; halt = 1'b0; instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
      n_total++; if (fetch_count !== 16'(pops)) $display("FAIL rnd_fetch_count: got %0d want %0d", fetch_count, pops); else n_pass++;
      n_total++; if (flush_count !== 16'(flushes)) $display("FAIL rnd_flush_count: got %0d want %0d", flush_count, flushes); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_startup();
      test_backpressure();
      test_wrap();
      test_redirect();
      test_halt();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
